// File: rtl/sa_pkg.sv
// Shared systolic-array constants and helpers: sum width, column slice offsets,
// and the width of FIFO level counters.
package sa_pkg;

  function automatic int sum_width(input int data_width);
    return data_width * data_width;
  endfunction

  // Low bit of column j inside a packed multi-column bus.
  function automatic int col_lo(input int col, input int slice_width);
    return col * slice_width;
  endfunction

  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sa_row_fifo.sv
// First-word-fall-through row FIFO. A write while full is accepted only when a
// pop happens on the same edge; otherwise the write is ignored.
module sa_row_fifo
  import sa_pkg::*;
#(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int LW    = level_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  localparam int AW = LW - 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [LW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             push, pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (level_o == DEPTH_L);
  assign empty_o = (level_o == '0);

  assign pop  = rd_en_i && !empty_o;
  assign push = wr_en_i && (!full_o || pop);

  assign wr_ptr_d = push ? wr_ptr_q + LW'(1) : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + LW'(1) : rd_ptr_q;

  // Head is forced to zero while empty so the output is clean after reset.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/sa_result_drain.sv
// Bottom-row collector: deskews the per-column partial sums into one aligned row,
// buffers rows in a FIFO and flags (never back-pressures) overflow.
module sa_result_drain
  import sa_pkg::*;
#(
  parameter  int DATA_WIDTH = 4,
  parameter  int COLS       = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int SW         = sum_width(DATA_WIDTH),
  localparam int LW         = level_width(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [COLS*SW-1:0] in_sums,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [COLS*SW-1:0] out_row,
  output logic [LW-1:0]    out_level,
  output logic             overflow
);

  logic [COLS*SW-1:0] aligned;
  logic               wr_en;
  logic               fifo_full, fifo_empty;
  logic               overflow_q;

  // Column j arrives j cycles late, so it waits COLS-1-j cycles to line up.
  for (genvar j = 0; j < COLS; j++) begin : g_col
    localparam int D = COLS - 1 - j;
    if (D == 0) begin : g_direct
      assign aligned[col_lo(j, SW) +: SW] = in_sums[col_lo(j, SW) +: SW];
    end else begin : g_dly
      logic [SW-1:0] dl_q [D];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < D; k++) dl_q[k] <= '0;
        end else begin
          dl_q[0] <= in_sums[col_lo(j, SW) +: SW];
          for (int k = 1; k < D; k++) dl_q[k] <= dl_q[k-1];
        end
      end
      assign aligned[col_lo(j, SW) +: SW] = dl_q[D-1];
    end
  end

  if (COLS == 1) begin : g_vld_none
    assign wr_en = in_valid;
  end else begin : g_vld
    localparam int VW = COLS - 1;
    logic [VW-1:0] vld_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) vld_q <= '0;
      else       vld_q <= VW'({vld_q, in_valid});
    end
    assign wr_en = vld_q[VW-1];
  end

  sa_row_fifo #(
    .WIDTH (COLS * SW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_en),
    .wr_data_i (aligned),
    .rd_en_i   (out_ready),
    .rd_data_o (out_row),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (out_level)
  );

  assign out_valid = !fifo_empty;

  // A full FIFO still takes the row if the consumer frees a slot this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               overflow_q <= 1'b0;
    else if (wr_en && fifo_full && !out_ready) overflow_q <= 1'b1;
  end

  assign overflow = overflow_q;

endmodule

// File: tb/tb_sa_result_drain.sv
// Bench for sa_result_drain: skew feeder, row-level FIFO model, per-cycle compare
// and directed pins for each scenario.
module tb_sa_result_drain;

  localparam int COLS  = 4;
  localparam int SW    = 16;
  localparam int W     = COLS * SW;
  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [W-1:0]  in_sums;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_row;
  logic [LW-1:0] out_level;
  logic          overflow;

  sa_result_drain #(
    .DATA_WIDTH (4),
    .COLS       (COLS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_sums   (in_sums),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_level (out_level),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_reset_cyc = 0;

  // Scheduled rows: start cycle of column 0 and the full row value.
  int           row_start [$];
  logic [W-1:0] row_data  [$];

  // Expected FIFO contents and sticky overflow.
  logic [W-1:0] exp_q [$];
  logic         m_ovf = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_row(input logic [15:0] base);
    return {base + 16'd3, base + 16'd2, base + 16'd1, base};
  endfunction

  task automatic schedule(input int start, input logic [15:0] base);
    row_start.push_back(start);
    row_data.push_back(mk_row(base));
  endtask

  // Wait until the falling edge inside cycle n.
  task automatic goto(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  always @(posedge reset) begin
    exp_q.delete();
    m_ovf = 1'b0;
  end

  // Model update at each edge, then drive the skewed inputs for the next cycle.
  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_ovf = 1'b0;
      last_reset_cyc = cyc;
    end else begin
      logic         wr;
      logic [W-1:0] wd;
      wr = 1'b0;
      wd = '0;
      for (int i = 0; i < row_start.size(); i++)
        if (row_start[i] + COLS - 1 == cyc && row_start[i] > last_reset_cyc) begin
          wr = 1'b1;
          wd = row_data[i];
        end
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (wr) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(wd);
        else m_ovf = 1'b1;
      end
    end
    cyc = cyc + 1;
    #1;
    in_valid = 1'b0;
    for (int j = 0; j < COLS; j++) in_sums[j*SW +: SW] = 16'($urandom);
    for (int i = 0; i < row_start.size(); i++) begin
      if (row_start[i] == cyc) in_valid = 1'b1;
      for (int j = 0; j < COLS; j++)
        if (row_start[i] + j == cyc) in_sums[j*SW +: SW] = row_data[i][j*SW +: SW];
    end
  end

  always @(negedge clk) begin
    if (cyc >= 3) begin
      chk("valid", W'(out_valid), W'(exp_q.size() != 0));
      chk("level", W'(out_level), W'(exp_q.size()));
      chk("ovf",   W'(overflow),  W'(m_ovf));
      if (exp_q.size() != 0) chk("row", out_row, exp_q[0]);
    end
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sums   = '0;
    out_ready = 1'b1;

    goto(2);
    chk("rst_valid", W'(out_valid), W'(0));
    chk("rst_row",   out_row,       W'(0));
    chk("rst_level", W'(out_level), W'(0));
    chk("rst_ovf",   W'(overflow),  W'(0));
    reset = 1'b0;

    // Single row
    schedule(10, 16'h1000);
    goto(13); chk("single_early", W'(out_valid), W'(0));
    goto(14); chk("single_valid", W'(out_valid), W'(1));
              chk("single_row",   out_row, 64'h1003_1002_1001_1000);
    goto(15); chk("single_after", W'(out_valid), W'(0));
              chk("single_lvl0",  W'(out_level), W'(0));

    // Streaming
    for (int r = 0; r < 8; r++) schedule(20 + r, 16'(r * 16));
    goto(24); chk("stream_first", out_row, 64'h0003_0002_0001_0000);
    goto(31); chk("stream_last",  out_row, 64'h0073_0072_0071_0070);
    goto(32); chk("stream_ovf",   W'(overflow), W'(0));

    // Backpressure, then overflow
    goto(39); out_ready = 1'b0;
    for (int r = 0; r < 4; r++) schedule(40 + r, 16'(16'h0200 + r * 16));
    schedule(50, 16'h0400);
    goto(48); chk("full_level", W'(out_level), W'(4));
              chk("full_head",  out_row, 64'h0203_0202_0201_0200);
    goto(50); chk("full_hold",  out_row, 64'h0203_0202_0201_0200);
    goto(53); chk("ovf_before", W'(overflow), W'(0));
    goto(54); chk("ovf_set",    W'(overflow), W'(1));
              chk("ovf_level",  W'(out_level), W'(4));
    goto(56); out_ready = 1'b1;
    goto(59); chk("drain_last", out_row, 64'h0233_0232_0231_0230);
    goto(60); chk("drain_lvl0", W'(out_level), W'(0));
              chk("ovf_sticky", W'(overflow), W'(1));

    // Reset mid-stream: 2 rows buffered, 2 in the delay lines
    goto(65); out_ready = 1'b0;
    schedule(70, 16'h0700);
    schedule(71, 16'h0710);
    schedule(74, 16'h0740);
    schedule(75, 16'h0750);
    goto(76); chk("pre_rst_lvl", W'(out_level), W'(2));
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", W'(out_valid), W'(0));
    chk("mid_rst_level", W'(out_level), W'(0));
    chk("mid_rst_ovf",   W'(overflow),  W'(0));
    goto(78); reset = 1'b0; out_ready = 1'b1;
    schedule(85, 16'h0600);
    goto(88); chk("post_rst_early", W'(out_valid), W'(0));
    goto(89); chk("post_rst_row",   out_row, 64'h0603_0602_0601_0600);
    goto(90); chk("post_rst_alone", W'(out_valid), W'(0));

    // Full with a pop on the incoming write
    goto(95); out_ready = 1'b0;
    for (int r = 0; r < 5; r++) schedule(100 + r + (r == 4 ? 3 : 0), 16'(16'h0500 + r * 16));
    goto(110); out_ready = 1'b1;
    goto(111); out_ready = 1'b0;
    chk("fp_level", W'(out_level), W'(4));
    chk("fp_ovf",   W'(overflow),  W'(0));
    chk("fp_head",  out_row, 64'h0513_0512_0511_0510);
    goto(113); out_ready = 1'b1;
    goto(116); chk("fp_new_row", out_row, 64'h0543_0542_0541_0540);
    goto(118); chk("fp_lvl0", W'(out_level), W'(0));
               chk("fp_ovf_end", W'(overflow), W'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
